// File: rtl/handshake_initiator_pkg.sv
// Shared definitions for the 4-phase req/ack initiator.
//   hs_state_e  : FSM state encoding, common with the responder side
//                 (IDLE=0, REQ=1, ACKW=2, ERR=3)
//   DEF_*       : default widths/depth/timeout used by the top-level parameters
package handshake_initiator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACKW = 2'd2,
    ST_ERR  = 2'd3
  } hs_state_e;

  localparam int DEF_DW      = 8;
  localparam int DEF_SW      = 16;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/handshake_initiator_fifo.sv
// Synchronous FIFO buffering bytes between the local writer and the handshake FSM.
//   clk, rstn   : clock, synchronous active-low reset (flushes pointers/count)
//   i_wr_en     : push request; ignored when full
//   i_wr_data   : byte to push
//   i_rd_en     : pop request; ignored when empty
//   o_rd_data   : current head entry (valid when !o_empty)
//   o_full      : DEPTH entries held
//   o_empty     : no entries held
module hs_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_wr_en,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_rd_en,
  output logic [DW-1:0] o_rd_data,
  output logic          o_full,
  output logic          o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_push;
  logic w_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_rd_data = r_mem[r_rd_ptr];

  // A write while full is dropped even if a pop frees a slot on the same edge.
  assign w_push = i_wr_en && !o_full;
  assign w_pop  = i_rd_en && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/handshake_initiator.sv
// Initiator side of the 4-phase req/ack byte link.
// Buffers bytes from a local writer and presents them one at a time on req_out/data_out,
// keeping a running sum and count of acknowledged bytes, a stall timeout and an overflow flag.
//   clk, rstn          : clock, synchronous active-low reset
//   wr_en, wr_data     : local write port (accepted when !full)
//   full, empty        : FIFO status
//   req_out, ack_in    : 4-phase handshake with the responder (same clock domain)
//   data_out           : byte under transfer, held until the next transfer starts
//   busy               : FSM not in IDLE
//   sum_out, sent_cnt  : running sum / count of acknowledged bytes (wrap mod 2^SW)
//   err_out, ovf_out   : sticky timeout / overflow flags
//   clr_err            : pulse clearing both sticky flags (and leaving ERR when ack_in=0)
module handshake_initiator
  import handshake_initiator_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int SW      = DEF_SW,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          full,
  output logic          empty,
  output logic          req_out,
  input  logic          ack_in,
  output logic [DW-1:0] data_out,
  output logic          busy,
  output logic [SW-1:0] sum_out,
  output logic [SW-1:0] sent_cnt,
  output logic          err_out,
  output logic          ovf_out,
  input  logic          clr_err
);

  localparam int            TW   = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  // Timer holds at all-ones rather than wrapping back to zero.
  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  hs_state_e     r_state;
  logic [TW-1:0] r_timer;
  logic          r_req;
  logic [DW-1:0] r_data;
  logic [SW-1:0] r_sum;
  logic [SW-1:0] r_cnt;
  logic          r_err;
  logic          r_ovf;

  logic          w_pop;
  logic [DW-1:0] w_head;
  logic          w_full;
  logic          w_empty;

  assign w_pop = (r_state == ST_IDLE) && !w_empty;

  hs_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .i_wr_en   (wr_en),
    .i_wr_data (wr_data),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_req   <= 1'b0;
      r_data  <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      // A new overflow on the same edge as clr_err wins over the clear.
      if (wr_en && w_full) begin
        r_ovf <= 1'b1;
      end else if (clr_err) begin
        r_ovf <= 1'b0;
      end

      // Later assignments in the FSM (timeout entry, ERR hold) override this clear.
      if (clr_err) begin
        r_err <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_data  <= w_head;
            r_req   <= 1'b1;
            r_timer <= '0;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (ack_in) begin
            r_req   <= 1'b0;
            r_sum   <= r_sum + SW'(r_data);
            r_cnt   <= r_cnt + 1'b1;
            r_timer <= '0;
            r_state <= ST_ACKW;
          end else if (r_timer == TMAX) begin
            // Byte in flight is abandoned without being counted.
            r_req   <= 1'b0;
            r_err   <= 1'b1;
            r_state <= ST_ERR;
          end else begin
            r_timer <= sat_inc(r_timer);
          end
        end
        ST_ACKW: begin
          if (!ack_in) begin
            r_state <= ST_IDLE;
          end else if (r_timer == TMAX) begin
            r_err   <= 1'b1;
            r_state <= ST_ERR;
          end else begin
            r_timer <= sat_inc(r_timer);
          end
        end
        ST_ERR: begin
          r_req <= 1'b0;
          // Only leave once the responder has released ack, so the next REQ starts clean.
          if (clr_err && !ack_in) begin
            r_err   <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_err   <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign full     = w_full;
  assign empty    = w_empty;
  assign req_out  = r_req;
  assign data_out = r_data;
  assign busy     = (r_state != ST_IDLE);
  assign sum_out  = r_sum;
  assign sent_cnt = r_cnt;
  assign err_out  = r_err;
  assign ovf_out  = r_ovf;

endmodule

// File: tb/tb_handshake_initiator.sv
// Bench for handshake_initiator: a writer, a responder model with programmable
// ack/drop delays, and a byte queue holding the bytes expected on data_out.
module tb_handshake_initiator;

  localparam int DW      = 8;
  localparam int SW      = 16;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic          clk = 1'b0;
  logic          rstn;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full;
  logic          empty;
  logic          req_out;
  logic          ack_in;
  logic [DW-1:0] data_out;
  logic          busy;
  logic [SW-1:0] sum_out;
  logic [SW-1:0] sent_cnt;
  logic          err_out;
  logic          ovf_out;
  logic          clr_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] sb [$];
  logic [SW-1:0] exp_sum;
  logic [SW-1:0] exp_cnt;
  logic          exp_ovf;

  logic ack_never;
  int   ack_dly;
  int   drop_dly;
  int   rs;
  int   rcnt;

  handshake_initiator #(
    .DW      (DW),
    .SW      (SW),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .req_out  (req_out),
    .ack_in   (ack_in),
    .data_out (data_out),
    .busy     (busy),
    .sum_out  (sum_out),
    .sent_cnt (sent_cnt),
    .err_out  (err_out),
    .ovf_out  (ovf_out),
    .clr_err  (clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic raise_ack();
    logic [DW-1:0] b;
    ack_in = 1'b1;
    rs     = 2;
    if (sb.size() == 0) begin
      chk_val("sb_underflow", 32'(sb.size()), 32'd1);
    end else begin
      b = sb.pop_front();
      chk_val("data_out", 32'(data_out), 32'(b));
      exp_sum = exp_sum + SW'(b);
      exp_cnt = exp_cnt + 1'b1;
    end
  endtask

  // Responder: acts one cycle at a time, looking at outputs just after each rising edge.
  initial begin
    ack_in = 1'b0;
    rs     = 0;
    rcnt   = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rstn) begin
        ack_in = 1'b0;
        rs     = 0;
      end else begin
        case (rs)
          0: if (req_out && !ack_never) begin
               if (ack_dly == 0) raise_ack();
               else begin rcnt = ack_dly; rs = 1; end
             end
          1: begin
               rcnt--;
               if (rcnt == 0) raise_ack();
             end
          2: if (!req_out) begin
               if (drop_dly == 0) begin ack_in = 1'b0; rs = 0; end
               else begin rcnt = drop_dly; rs = 3; end
             end
          3: begin
               rcnt--;
               if (rcnt == 0) begin ack_in = 1'b0; rs = 0; end
             end
          default: rs = 0;
        endcase
      end
    end
  end

  // Called just after a rising edge; the write lands on the next edge.
  task automatic wr_byte(input logic [DW-1:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    if (!full) sb.push_back(b);
    else       exp_ovf = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic wr_when_room(input logic [DW-1:0] b);
    int g = 0;
    while (full && g < 50) begin
      @(posedge clk);
      #1;
      g++;
    end
    wr_byte(b);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int n = 0;
    while (n < max_cyc) begin
      tick();
      n++;
      if (!busy && empty && !ack_in && sb.size() == 0) break;
    end
    chk_val(tag, 32'(n < max_cyc), 32'd1);
  endtask

  task automatic wait_req(input string tag, input int max_cyc);
    int n = 0;
    while (!req_out && n < max_cyc) begin
      tick();
      n++;
    end
    chk_val(tag, 32'(req_out), 32'd1);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  task automatic do_reset();
    rstn    = 1'b0;
    wr_en   = 1'b0;
    clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb.delete();
    exp_sum = '0;
    exp_cnt = '0;
    exp_ovf = 1'b0;
    rstn    = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [DW-1:0] dropped;
    rstn      = 1'b0;
    wr_en     = 1'b0;
    wr_data   = '0;
    clr_err   = 1'b0;
    ack_never = 1'b0;
    ack_dly   = 0;
    drop_dly  = 0;
    exp_sum   = '0;
    exp_cnt   = '0;
    exp_ovf   = 1'b0;

    // Reset state
    do_reset();
    chk_val("rst_req",   32'(req_out),  32'd0);
    chk_val("rst_data",  32'(data_out), 32'd0);
    chk_val("rst_empty", 32'(empty),    32'd1);
    chk_val("rst_full",  32'(full),     32'd0);
    chk_val("rst_busy",  32'(busy),     32'd0);
    chk_val("rst_sum",   32'(sum_out),  32'd0);
    chk_val("rst_cnt",   32'(sent_cnt), 32'd0);
    chk_val("rst_err",   32'(err_out),  32'd0);
    chk_val("rst_ovf",   32'(ovf_out),  32'd0);

    // 1: single byte, ack 3 cycles after req, drop 2 cycles after req falls
    ack_dly  = 3;
    drop_dly = 2;
    wr_byte(8'h41);
    chk_val("t1_req_early", 32'(req_out), 32'd0);
    tick();
    chk_val("t1_req_lat",  32'(req_out),  32'd1);
    chk_val("t1_data",     32'(data_out), 32'h41);
    chk_val("t1_busy",     32'(busy),     32'd1);
    wait_idle("t1_idle", 100);
    chk_val("t1_sum", 32'(sum_out),  32'h0041);
    chk_val("t1_cnt", 32'(sent_cnt), 32'd1);

    // 2: burst of three bytes
    do_reset();
    ack_dly  = 1;
    drop_dly = 1;
    wr_byte(8'h41);
    wr_byte(8'h51);
    wr_byte(8'h11);
    wait_idle("t2_idle", 200);
    chk_val("t2_sum", 32'(sum_out),  32'h00A3);
    chk_val("t2_cnt", 32'(sent_cnt), 32'd3);
    chk_val("t2_ovf", 32'(ovf_out),  32'd0);

    // 3: 258 x 0xFF with immediate ack, sum wraps
    do_reset();
    ack_dly  = 0;
    drop_dly = 0;
    for (int i = 0; i < 258; i++) wr_when_room(8'hFF);
    wait_idle("t3_idle", 200);
    chk_val("t3_sum",       32'(sum_out),  32'h00FE);
    chk_val("t3_cnt",       32'(sent_cnt), 32'd258);
    chk_val("t3_model_sum", 32'(sum_out),  32'(exp_sum));
    chk_val("t3_ovf",       32'(ovf_out),  32'd0);

    // 4: ack never rises -> timeout after TIMEOUT cycles in REQ
    do_reset();
    ack_never = 1'b1;
    wr_byte(8'h22);
    wait_req("t4_req", 10);
    cyc = 0;
    while (!err_out && cyc < 200) begin
      tick();
      cyc++;
    end
    chk_val("t4_timeout_cyc", 32'(cyc),      32'(TIMEOUT));
    chk_val("t4_req",         32'(req_out),  32'd0);
    chk_val("t4_busy",        32'(busy),     32'd1);
    chk_val("t4_sum",         32'(sum_out),  32'd0);
    chk_val("t4_cnt",         32'(sent_cnt), 32'd0);
    tick();
    chk_val("t4_err_sticky",  32'(err_out),  32'd1);
    dropped = sb.pop_front();
    chk_val("t4_dropped", 32'(dropped), 32'h22);
    pulse_clr();
    chk_val("t4_err_clr",  32'(err_out), 32'd0);
    chk_val("t4_busy_clr", 32'(busy),    32'd0);
    ack_never = 1'b0;
    wr_byte(8'h33);
    wait_idle("t4_idle", 100);
    chk_val("t4_sum_after", 32'(sum_out),  32'h0033);
    chk_val("t4_cnt_after", 32'(sent_cnt), 32'd1);

    // 5: ack held low, six writes -> one in flight, four buffered, one dropped
    do_reset();
    ack_never = 1'b1;
    for (int i = 1; i <= 6; i++) wr_byte(8'(i * 16));
    chk_val("t5_full",   32'(full),     32'd1);
    chk_val("t5_ovf",    32'(ovf_out),  32'd1);
    chk_val("t5_expovf", 32'(ovf_out),  32'(exp_ovf));
    chk_val("t5_req",    32'(req_out),  32'd1);
    chk_val("t5_data",   32'(data_out), 32'h10);
    chk_val("t5_sbsize", 32'(sb.size()), 32'd5);
    pulse_clr();
    chk_val("t5_ovf_clr", 32'(ovf_out), 32'd0);
    chk_val("t5_busy",    32'(busy),    32'd1);
    ack_never = 1'b0;
    wait_idle("t5_idle", 200);
    chk_val("t5_sum",       32'(sum_out),  32'h00F0);
    chk_val("t5_model_sum", 32'(sum_out),  32'(exp_sum));
    chk_val("t5_cnt",       32'(sent_cnt), 32'd5);
    chk_val("t5_err",       32'(err_out),  32'd0);

    // 6: reset while req_out is high
    do_reset();
    ack_dly  = 0;
    drop_dly = 0;
    wr_byte(8'h07);
    wait_idle("t6_pre_idle", 100);
    chk_val("t6_pre_sum", 32'(sum_out), 32'h0007);
    ack_never = 1'b1;
    wr_byte(8'h55);
    wr_byte(8'h66);
    wait_req("t6_req", 10);
    rstn = 1'b0;
    tick();
    chk_val("t6_req",   32'(req_out),  32'd0);
    chk_val("t6_empty", 32'(empty),    32'd1);
    chk_val("t6_sum",   32'(sum_out),  32'd0);
    chk_val("t6_cnt",   32'(sent_cnt), 32'd0);
    chk_val("t6_busy",  32'(busy),     32'd0);
    sb.delete();
    exp_sum   = '0;
    exp_cnt   = '0;
    rstn      = 1'b1;
    ack_never = 1'b0;
    tick();
    wr_byte(8'h99);
    wait_idle("t6_idle", 100);
    chk_val("t6_sum_after", 32'(sum_out),  32'h0099);
    chk_val("t6_cnt_after", 32'(sent_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
